// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the nibble-serial add/sub controller
//
// Purpose: FSM state encoding, slice width and operation encoding shared by
//          nibble_serial_addsub_ctrl and full_adder_subtractor_4bit.
// Contents: state_t {IDLE, RUN, DONE}, NIB_W, OP_ADD, OP_SUB.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_subtractor_4bit.sv
// rtl/full_adder_subtractor_4bit.sv - 4-bit ripple adder slice shared across nibbles
//
// Purpose: one NIB_W-bit ripple-carry slice. Subtraction is performed by the
//          caller presenting an inverted b and a carry-in of 1.
// Ports:
//   a, b  in   NIB_W  operand nibbles
//   cin   in   1      carry into bit 0
//   sum   out  NIB_W  a + b + cin (low NIB_W bits)
//   cout  out  1      carry out of the top bit
module full_adder_subtractor_4bit
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - WIDTH-bit add/sub sequenced over one shared 4-bit slice
//
// Purpose: accepts operands on a valid/ready handshake, runs the 4-bit slice
//          over WIDTH/4 cycles least-significant nibble first with a registered
//          inter-nibble carry, then holds the result until the consumer accepts.
// Optional feature macro: ADDSUB_FLAGS_EN (zero/overflow flag logic; tied to 0
//          when undefined).
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and op valid
//   in_ready   out  1      controller idle, can accept operands
//   op_a       in   WIDTH  minuend/addend
//   op_b       in   WIDTH  subtrahend/addend
//   sub        in   1      0 = a+b, 1 = a-b
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  sum/difference modulo 2^WIDTH
//   carry_out  out  1      final carry (for sub, 1 = no borrow)
//   zero       out  1      result == 0 (ADDSUB_FLAGS_EN)
//   overflow   out  1      signed overflow (ADDSUB_FLAGS_EN)
module nibble_serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_addsub_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   next_result;
  logic               last_nib;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_nib  = (cnt == CNT_W'(NIB - 1));

  // Nibble selection and result merge are written as explicit muxes so the
  // counter never has to be scaled into a bit index.
  always_comb begin
    a_nib       = '0;
    b_nib       = '0;
    next_result = result;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_nib                          = a_reg[i*NIB_W +: NIB_W];
        b_nib                          = b_reg[i*NIB_W +: NIB_W];
        next_result[i*NIB_W +: NIB_W]  = slice_sum;
      end
    end
  end

  full_adder_subtractor_4bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_nib)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // b is stored pre-inverted for subtract; the carry register then supplies
  // the +1 of the two's-complement negation on the first nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b ^ {WIDTH{sub}};
            carry_reg <= (sub == OP_SUB);
            cnt       <= '0;
          end
        end
        RUN: begin
          result    <= next_result;
          carry_reg <= slice_cout;
          if (last_nib) begin
            cnt       <= '0;
            carry_out <= slice_cout;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic zero_q;
  logic overflow_q;

  // Carry into the MSB is recovered from the MSB sum bit, so no tap inside
  // the slice is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == RUN && last_nib) begin
      zero_q     <= (next_result == '0);
      overflow_q <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[NIB_W-1]) ^ slice_cout;
    end
  end

  assign zero     = zero_q;
  assign overflow = overflow_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - directed self-checking bench for nibble_serial_addsub_ctrl
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        zero;
  logic        overflow;

  int checks;
  int passed;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  nibble_serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation, called #1 after a rising edge with the DUT idle.
  // Returns cycles from the accept edge until out_valid is seen (99 = timeout).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = 16'hA5A5;
    op_b     = 16'h5A5A;
    sub      = ~s;
    lat      = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] exp_res, input logic exp_c,
                          input logic exp_z, input logic exp_v);
    int lat;
    logic ez, ev;
    ez = FLAGS ? exp_z : 1'b0;
    ev = FLAGS ? exp_v : 1'b0;
    issue(a, b, s, lat);
    checks++;
    if (lat !== 4) $display("FAIL %s latency: got %0d expected 4", name, lat);
    else passed++;
    checks++;
    if (result !== exp_res) $display("FAIL %s result: got %h expected %h", name, result, exp_res);
    else passed++;
    checks++;
    if (carry_out !== exp_c) $display("FAIL %s carry_out: got %b expected %b", name, carry_out, exp_c);
    else passed++;
    checks++;
    if (zero !== ez) $display("FAIL %s zero: got %b expected %b", name, zero, ez);
    else passed++;
    checks++;
    if (overflow !== ev) $display("FAIL %s overflow: got %b expected %b", name, overflow, ev);
    else passed++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL %s in_ready in DONE: got %b expected 0", name, in_ready);
    else passed++;
    accept_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, result, carry_out, zero, overflow} !== {1'b1, 1'b0, 16'h0, 3'b000})
      $display("FAIL reset outputs: got in_ready=%b out_valid=%b result=%h c=%b z=%b v=%b expected 1 0 0000 0 0 0",
               in_ready, out_valid, result, carry_out, zero, overflow);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset release in_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_add();
    check_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    check_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    check_op("sub_9_9", 16'h0009, 16'h0009, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    check_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    check_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h00F0, 16'h0F10, 1'b0, lat);
    checks++;
    if (lat !== 4 || result !== 16'h1000)
      $display("FAIL bp first result: lat=%0d result=%h expected 4 1000", lat, result);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h1000 || carry_out !== 1'b0)
        $display("FAIL bp hold cycle %0d: out_valid=%b in_ready=%b result=%h c=%b expected 1 0 1000 0",
                 i, out_valid, in_ready, result, carry_out);
      else passed++;
    end
    in_valid = 1'b0;
    accept_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_abort_reset();
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result, carry_out, zero, overflow} !== {1'b1, 1'b0, 16'h0, 3'b000})
      $display("FAIL abort outputs: in_ready=%b out_valid=%b result=%h c=%b z=%b v=%b expected 1 0 0000 0 0 0",
               in_ready, out_valid, result, carry_out, zero, overflow);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_op("post_abort_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_abort_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
